param_ram_ctrl: RTL and testbench
=================================

// Module: param_ram_ctrl
//
// PURPOSE
// Parametrised single-port synchronous RAM with a built-in clear sequencer; next-generation data RAM for
// the 8-bit 5-stage core (MEM stage). Separate write/read data buses (no tri-state), registered read with
// a valid strobe, busy flag during hardware clear, out-of-range address detection, optional parity check.
//
// PARAMETERS
// DATA_WIDTH   8     word width in bits
// ADDR_WIDTH   4     address bus width
// DEPTH        16    implemented words, 1..2**ADDR_WIDTH; addresses >= DEPTH are out of range
// CLEAR_VALUE  0     value written to every word by the clear sequencer (DATA_WIDTH bits)
//
// PORTS
// clock         in   1           system clock, all state on rising edge
// reset         in   1           asynchronous, active-low system reset
// ram_enable    in   1           active-low chip enable; wr_en/rd_en ignored when 1
// wr_en         in   1           active-high write request
// rd_en         in   1           active-high read request
// clear_req     in   1           active-high pulse: re-run clear sequencer
// address_bus   in   ADDR_WIDTH  word address
// wr_data       in   DATA_WIDTH  write data
// rd_data       out  DATA_WIDTH  registered read data; holds last value
// rd_valid      out  1           one-cycle strobe: rd_data updated this cycle
// rd_err        out  1           one-cycle strobe with rd_valid: read address was out of range
// busy          out  1           1 while clear sequencer runs; all requests ignored
//
// BEHAVIOUR
// - Reset (reset=0, async): rd_data=0, rd_valid=0, rd_err=0, busy=1, state=CLEAR, clear_ptr=0.
//   Memory array contents not reset directly; cleared by sequencer.
// - FSM: CLEAR -> READY when clear_ptr==DEPTH-1 written; READY -> CLEAR on clear_req=1 (ptr=0).
// - CLEAR: each posedge writes CLEAR_VALUE to mem[clear_ptr], ptr++; exactly DEPTH cycles. busy=1
//   throughout; busy=0 from the posedge writing the last word. clear_req in CLEAR ignored (no restart).
// - Reset asserted mid-clear or mid-access: immediate return to reset state; clear restarts at 0.
// - Access accepted at posedge when state=READY, ram_enable=0, clear_req=0. clear_req wins over same-cycle access.
// - Write: mem[address_bus] <= wr_data at accepting posedge; address >= DEPTH -> write dropped, no flag.
// - Read: latency 1; at accepting posedge rd_data <= mem[address_bus], rd_valid <= 1. Back-to-back
//   reads every cycle allowed. Address >= DEPTH -> rd_data <= 0, rd_err <= 1 with rd_valid.
// - wr_en & rd_en same cycle, same address: read-first; rd_data = old word, new word stored.
// - rd_valid/rd_err return to 0 the cycle after any posedge with no accepted read.
// - Address arithmetic: clear_ptr is ADDR_WIDTH bits, no wrap beyond DEPTH-1.
//
// CONFIGURATION
// PARAM_RAM_PARITY_EN defined:
//   - storage DATA_WIDTH+1 bits; bit DATA_WIDTH = even parity (XOR) of wr_data, computed on write/clear.
//   - extra ports: parity_inject in 1 (when 1 on accepted write, stored parity bit inverted, test hook);
//     parity_err out 1 (strobe with rd_valid: recomputed parity != stored; reset value 0; 0 on rd_err reads).
//   - rd_data still delivered unchanged on parity error.
// Not defined: no parity storage, no parity_inject/parity_err ports; all other behaviour identical.
//
// TESTING
// 1. reset 0->1, DEPTH=16 -> busy=1 for exactly 16 posedges after release; then read all 16 -> rd_data=00.
// 2. write addr i data i for i=0..15, then read i=0..15 -> rd_data=i, rd_valid=1 exactly one cycle later.
// 3. mem[5]=05; wr_en=rd_en=1, addr 5, wr_data AA -> rd_data=05; next read addr 5 -> AA.
// 4. fill with 55, pulse clear_req, write 77 to addr 3 while busy -> dropped; after busy=0 all reads 00.
// 5. DEPTH=12: write FF to addr 13, read addr 13 -> rd_data=00, rd_err=1, rd_valid=1; addr 11 rd_err=0.
// 6. PARAM_RAM_PARITY_EN: write 3C addr 2 with parity_inject=1, read -> rd_data=3C, parity_err=1;
//    rewrite without inject, read -> parity_err=0. Also reset mid-clear (ptr=7) -> busy stays 1 16 cycles.

Source files
------------

// File: rtl/param_ram_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : param_ram_ctrl_if                                             |
// | Purpose  : Access bus for param_ram_ctrl (requests, read data, status).  |
// |            Parity hook signals exist only with PARAM_RAM_PARITY_EN.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface param_ram_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  ram_enable;
    logic                  wr_en;
    logic                  rd_en;
    logic                  clear_req;
    logic [ADDR_WIDTH-1:0] address_bus;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_err;
    logic                  busy;
`ifdef PARAM_RAM_PARITY_EN
    logic                  parity_inject;
    logic                  parity_err;

    modport master (
        output ram_enable, wr_en, rd_en, clear_req, address_bus, wr_data, parity_inject,
        input  rd_data, rd_valid, rd_err, busy, parity_err
    );
    modport slave (
        input  ram_enable, wr_en, rd_en, clear_req, address_bus, wr_data, parity_inject,
        output rd_data, rd_valid, rd_err, busy, parity_err
    );
`else
    modport master (
        output ram_enable, wr_en, rd_en, clear_req, address_bus, wr_data,
        input  rd_data, rd_valid, rd_err, busy
    );
    modport slave (
        input  ram_enable, wr_en, rd_en, clear_req, address_bus, wr_data,
        output rd_data, rd_valid, rd_err, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/param_ram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : param_ram_ctrl                                                |
// | Purpose  : Single-port synchronous data RAM with clear sequencer,        |
// |            registered read/valid strobe and out-of-range detection.      |
// |            Optional parity storage/check with PARAM_RAM_PARITY_EN.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module param_ram_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DEPTH       = 16,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input wire              clock,
    input wire              reset,
    param_ram_ctrl_if.slave bus
);

`ifdef PARAM_RAM_PARITY_EN
    localparam int c_MEM_W = DATA_WIDTH + 1;
`else
    localparam int c_MEM_W = DATA_WIDTH;
`endif
    localparam logic [0:0]            c_S_CLEAR = 1'b0;
    localparam logic [0:0]            c_S_READY = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);

    logic [c_MEM_W-1:0]    r_mem [DEPTH];
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clear_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_err;

    logic               w_clearing;
    logic               w_in_range;
    logic               w_accept;
    logic               w_do_write;
    logic               w_do_read;
    logic [c_MEM_W-1:0] w_rd_word;
    logic [c_MEM_W-1:0] w_wr_word;
    logic [c_MEM_W-1:0] w_clr_word;

    assign w_clearing = (r_state == c_S_CLEAR);
    assign w_in_range = ({1'b0, bus.address_bus} < c_DEPTH);
    // A same-cycle clear request takes priority over any access.
    assign w_accept   = (r_state == c_S_READY) && !bus.ram_enable && !bus.clear_req;
    assign w_do_write = w_accept && bus.wr_en && w_in_range;
    assign w_do_read  = w_accept && bus.rd_en;
    assign w_rd_word  = r_mem[bus.address_bus];

`ifdef PARAM_RAM_PARITY_EN
    logic r_parity_err;

    assign w_wr_word  = {(^bus.wr_data) ^ bus.parity_inject, bus.wr_data};
    assign w_clr_word = {^CLEAR_VALUE, CLEAR_VALUE};
    assign bus.parity_err = r_parity_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_do_read && w_in_range &&
                            ((^w_rd_word[DATA_WIDTH-1:0]) != w_rd_word[DATA_WIDTH]);
        end
    end
`else
    assign w_wr_word  = bus.wr_data;
    assign w_clr_word = CLEAR_VALUE;
`endif

    // Array has no reset; the sequencer is gated off while reset is held low.
    always_ff @(posedge clock) begin
        if (reset && w_clearing) begin
            r_mem[r_clear_ptr] <= w_clr_word;
        end else if (w_do_write) begin
            r_mem[bus.address_bus] <= w_wr_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_S_CLEAR;
            r_clear_ptr <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_err    <= 1'b0;
        end else begin
            r_rd_valid <= w_do_read;
            r_rd_err   <= w_do_read && !w_in_range;
            if (w_do_read) begin
                r_rd_data <= w_in_range ? w_rd_word[DATA_WIDTH-1:0] : '0;
            end
            case (r_state)
                c_S_CLEAR: begin
                    if (r_clear_ptr == c_LAST) begin
                        r_state     <= c_S_READY;
                        r_clear_ptr <= '0;
                    end else begin
                        r_clear_ptr <= r_clear_ptr + 1'b1;
                    end
                end
                default: begin
                    if (bus.clear_req) begin
                        r_state     <= c_S_CLEAR;
                        r_clear_ptr <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_err   = r_rd_err;
    assign bus.busy     = w_clearing;

endmodule
`default_nettype wire

// File: tb/tb_param_ram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_param_ram_ctrl                                             |
// | Purpose  : Self-checking bench: DEPTH=16 and DEPTH=12 instances driven   |
// |            in lockstep against a word-array reference model.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_param_ram_ctrl;
    localparam int         DW  = 8;
    localparam int         AW  = 4;
    localparam int         DA  = 16;
    localparam int         DB  = 12;
    localparam logic [7:0] CVA = 8'h00;
    localparam logic [7:0] CVB = 8'hA5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    param_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    param_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    param_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DA), .CLEAR_VALUE(CVA)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );
    param_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DB), .CLEAR_VALUE(CVB)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // stimulus shared by both instances
    logic       en_n, we, re, clr, inj;
    logic [3:0] addr;
    logic [7:0] wd;

    // reference model: words remaining to clear, stored words/parity, last outputs
    int         m_cnt  [2];
    logic [7:0] m_mem  [2][16];
    logic       m_par  [2][16];
    logic [7:0] m_rd   [2];
    logic       m_vld  [2];
    logic       m_err  [2];
    logic       m_perr [2];

    int n_vec = 0;
    int n_err = 0;

    function automatic int dep(input int i);
        return (i == 0) ? DA : DB;
    endfunction

    function automatic logic [7:0] cval(input int i);
        return (i == 0) ? CVA : CVB;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = dep(i);
            m_rd[i]   = 8'h00;
            m_vld[i]  = 1'b0;
            m_err[i]  = 1'b0;
            m_perr[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_vld[i]  = 1'b0;
            m_err[i]  = 1'b0;
            m_perr[i] = 1'b0;
            if (m_cnt[i] > 0) begin
                m_mem[i][dep(i) - m_cnt[i]] = cval(i);
                m_par[i][dep(i) - m_cnt[i]] = ^cval(i);
                m_cnt[i]--;
            end else if (clr) begin
                m_cnt[i] = dep(i);
            end else if (!en_n) begin
                if (re) begin
                    m_vld[i] = 1'b1;
                    m_err[i] = !(int'(addr) < dep(i));
                    if (int'(addr) < dep(i)) begin
                        m_rd[i]   = m_mem[i][addr];
                        m_perr[i] = (^m_mem[i][addr]) != m_par[i][addr];
                    end else begin
                        m_rd[i] = 8'h00;
                    end
                end
                if (we && (int'(addr) < dep(i))) begin
                    m_mem[i][addr] = wd;
                    m_par[i][addr] = (^wd) ^ inj;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("busy_a",     8'(bus_a.busy),     8'(m_cnt[0] > 0));
        chk("rd_valid_a", 8'(bus_a.rd_valid), 8'(m_vld[0]));
        chk("rd_err_a",   8'(bus_a.rd_err),   8'(m_err[0]));
        chk("rd_data_a",  bus_a.rd_data,      m_rd[0]);
        chk("busy_b",     8'(bus_b.busy),     8'(m_cnt[1] > 0));
        chk("rd_valid_b", 8'(bus_b.rd_valid), 8'(m_vld[1]));
        chk("rd_err_b",   8'(bus_b.rd_err),   8'(m_err[1]));
        chk("rd_data_b",  bus_b.rd_data,      m_rd[1]);
`ifdef PARAM_RAM_PARITY_EN
        chk("parity_err_a", 8'(bus_a.parity_err), 8'(m_perr[0]));
        chk("parity_err_b", 8'(bus_b.parity_err), 8'(m_perr[1]));
`endif
    endtask

    task automatic drive();
        bus_a.ram_enable = en_n; bus_b.ram_enable = en_n;
        bus_a.wr_en      = we;   bus_b.wr_en      = we;
        bus_a.rd_en      = re;   bus_b.rd_en      = re;
        bus_a.clear_req  = clr;  bus_b.clear_req  = clr;
        bus_a.address_bus = addr; bus_b.address_bus = addr;
        bus_a.wr_data    = wd;   bus_b.wr_data    = wd;
`ifdef PARAM_RAM_PARITY_EN
        bus_a.parity_inject = inj; bus_b.parity_inject = inj;
`endif
    endtask

    task automatic cycle();
        drive();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        en_n = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0; inj = 1'b0;
        addr = 4'h0; wd = 8'h00;
        cycle();
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic pinj);
        en_n = 1'b0; we = 1'b1; re = 1'b0; clr = 1'b0; inj = pinj;
        addr = a; wd = d;
        cycle();
    endtask

    task automatic rd(input logic [3:0] a);
        en_n = 1'b0; we = 1'b0; re = 1'b1; clr = 1'b0; inj = 1'b0;
        addr = a; wd = 8'h00;
        cycle();
    endtask

    initial begin
        en_n = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0; inj = 1'b0;
        addr = 4'h0; wd = 8'h00;
        drive();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) begin
                m_mem[i][j] = 8'h00;
                m_par[i][j] = 1'b0;
            end
        end
        model_reset();
        #12;
        check_all();
        @(negedge clock);
        reset = 1'b1;

        // power-up clear, then read every word
        repeat (17) idle();
        for (int a = 0; a < 16; a++) rd(4'(a));

        // write address pattern and read back
        for (int a = 0; a < 16; a++) wr(4'(a), 8'(a), 1'b0);
        for (int a = 0; a < 16; a++) rd(4'(a));

        // read-first on simultaneous write/read
        wr(4'd5, 8'h05, 1'b0);
        en_n = 1'b0; we = 1'b1; re = 1'b1; clr = 1'b0; inj = 1'b0; addr = 4'd5; wd = 8'hAA;
        cycle();
        rd(4'd5);

        // clear during a filled array; write while busy is dropped
        for (int a = 0; a < 16; a++) wr(4'(a), 8'h55, 1'b0);
        en_n = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b1; addr = 4'd0; wd = 8'h00;
        cycle();
        wr(4'd3, 8'h77, 1'b0);
        repeat (16) idle();
        for (int a = 0; a < 16; a++) rd(4'(a));

        // out-of-range for the 12-word instance
        wr(4'd13, 8'hFF, 1'b0);
        rd(4'd13);
        rd(4'd11);

`ifdef PARAM_RAM_PARITY_EN
        wr(4'd2, 8'h3C, 1'b1);
        rd(4'd2);
        wr(4'd2, 8'h3C, 1'b0);
        rd(4'd2);
`endif

        // reset in the middle of a clear sweep
        en_n = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b1; addr = 4'd0; wd = 8'h00;
        cycle();
        repeat (7) idle();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b1;
        repeat (17) idle();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            en_n = ($urandom_range(0, 7) == 0);
            we   = 1'($urandom_range(0, 1));
            re   = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 39) == 0);
            addr = 4'($urandom_range(0, 15));
            wd   = 8'($urandom);
`ifdef PARAM_RAM_PARITY_EN
            inj  = ($urandom_range(0, 7) == 0);
`else
            inj  = 1'b0;
`endif
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
